bwt_mem_req_queue: RTL and testbench

//  Downstream neighbour of the backward control pipeline's CAL_KL stage. Buffers

---
 rtl/bwt_mem_req_queue_if.sv | 24 ++
 rtl/bwt_mem_req_queue.sv | 120 ++++++++++++
 tb/tb_bwt_mem_req_queue.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bwt_mem_req_queue_if.sv
// Memory read-request port of the backward occurrence request queue.
// The queue side (master) drives valid/addr/tag; the memory side (slave) drives ready.
interface bwt_mem_req_queue_if #(
   parameter int RN_W = 6
);
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [41:0]     mem_req_addr;
   logic [RN_W:0]   mem_req_tag;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      output mem_req_tag,
      input  mem_req_ready
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      input  mem_req_tag,
      output mem_req_ready
   );
endinterface

// File: rtl/bwt_mem_req_queue.sv
// Buffers backward occurrence requests {read_num, addr_k, addr_l} and serialises
// each into a tagged k read followed by an l read; raises the pipeline stall near full.
module bwt_mem_req_queue #(
   parameter int DEPTH        = 16,
   parameter int PTR_W        = 4,
   parameter int STALL_MARGIN = 2,
   parameter int RN_W         = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 request_valid,
   input  logic [RN_W-1:0]      read_num,
   input  logic [41:0]          addr_k,
   input  logic [41:0]          addr_l,
   output logic                 stall,
   bwt_mem_req_queue_if.master  mem,
   output logic [PTR_W:0]       occupancy,
   output logic                 overflow_err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEND_K = 2'd1;
   localparam logic [1:0] SEND_L = 2'd2;

   localparam logic [PTR_W:0]   DEPTH_V  = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   MARGIN_V = (PTR_W+1)'(STALL_MARGIN);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [RN_W-1:0]  ram_rn [DEPTH];
   logic [41:0]      ram_k  [DEPTH];
   logic [41:0]      ram_l  [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             full;
   logic             push;
   logic             drop;
   logic             pop;
   logic [PTR_W:0]   occ_next;
   logic [PTR_W:0]   free_next;

   assign full = (occupancy == DEPTH_V);
   // A request seen while stalled is simply not taken; upstream re-presents it.
   assign push = request_valid && !stall && !full;
   assign drop = request_valid && !stall && full;
   assign pop  = (state == SEND_L) && mem.mem_req_ready;

   always_comb begin
      occ_next = occupancy;
      case ({push, pop})
         2'b10:   occ_next = occupancy + OCC_ONE;
         2'b01:   occ_next = occupancy - OCC_ONE;
         default: occ_next = occupancy;
      endcase
   end

   assign free_next = DEPTH_V - occ_next;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (occupancy != '0) state_next = SEND_K;
         SEND_K:  if (mem.mem_req_ready) state_next = SEND_L;
         SEND_L:  if (mem.mem_req_ready) state_next = (occ_next != '0) ? SEND_K : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occupancy    <= '0;
         stall        <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         state     <= state_next;
         occupancy <= occ_next;
         stall     <= (free_next <= MARGIN_V);
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (drop) overflow_err <= 1'b1;
      end
   end

   // Entry storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         ram_rn[wr_ptr] <= read_num;
         ram_k[wr_ptr]  <= addr_k;
         ram_l[wr_ptr]  <= addr_l;
      end
   end

   always_comb begin
      mem.mem_req_valid = 1'b0;
      mem.mem_req_addr  = '0;
      mem.mem_req_tag   = '0;
      case (state)
         SEND_K: begin
            mem.mem_req_valid = 1'b1;
            mem.mem_req_addr  = ram_k[rd_ptr];
            mem.mem_req_tag   = {ram_rn[rd_ptr], 1'b0};
         end
         SEND_L: begin
            mem.mem_req_valid = 1'b1;
            mem.mem_req_addr  = ram_l[rd_ptr];
            mem.mem_req_tag   = {ram_rn[rd_ptr], 1'b1};
         end
         default: begin
            mem.mem_req_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bwt_mem_req_queue.sv
// Directed bench for bwt_mem_req_queue: hand-computed reads plus an ordered
// scoreboard of accepted requests against the k-then-l read stream.
module tb_bwt_mem_req_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        request_valid;
   logic [5:0]  read_num;
   logic [41:0] addr_k;
   logic [41:0] addr_l;
   logic        stall;
   logic [4:0]  occupancy;
   logic        overflow_err;

   bwt_mem_req_queue_if #(.RN_W(6)) mem_if ();

   bwt_mem_req_queue #(
      .DEPTH(16), .PTR_W(4), .STALL_MARGIN(2), .RN_W(6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .request_valid (request_valid),
      .read_num      (read_num),
      .addr_k        (addr_k),
      .addr_l        (addr_l),
      .stall         (stall),
      .mem           (mem_if.master),
      .occupancy     (occupancy),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_reads  = 0;
   bit rd_phase = 1'b0;
   logic [89:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge: scores the transfer/accept of the coming posedge, then advances one cycle.
   task automatic step(output bit acc);
      logic [89:0] head;
      if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
         if (exp_q.size() == 0) begin
            check("rd_unexpected", 64'd1, 64'd0);
         end else begin
            head = exp_q[0];
            check("rd_tag", 64'(mem_if.mem_req_tag), 64'({head[89:84], rd_phase}));
            check("rd_addr", 64'(mem_if.mem_req_addr), rd_phase ? 64'(head[41:0]) : 64'(head[83:42]));
            if (rd_phase) void'(exp_q.pop_front());
            rd_phase = ~rd_phase;
         end
         n_reads++;
      end
      acc = request_valid && !stall;
      if (acc) exp_q.push_back({read_num, addr_k, addr_l});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int rn, input logic [41:0] k, input logic [41:0] l);
      read_num = 6'(rn);
      addr_k   = k;
      addr_l   = l;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int j;
      int rn;
      int max_occ;
      int held_acc;
      int reads0;
      bit saw_fall;

      rst = 1'b0;
      request_valid = 1'b0;
      set_req(0, 42'h0, 42'h0);
      mem_if.mem_req_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_valid", 64'(mem_if.mem_req_valid), 64'd0);
      check("rst_addr", 64'(mem_if.mem_req_addr), 64'd0);
      check("rst_tag", 64'(mem_if.mem_req_tag), 64'd0);
      check("rst_ovf", 64'(overflow_err), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single request, ready held high
      mem_if.mem_req_ready = 1'b1;
      set_req(5, 42'h100, 42'h200);
      request_valid = 1'b1;
      step(acc);
      request_valid = 1'b0;
      check("s1_acc", 64'(acc), 64'd1);
      check("s1_occ_after_push", 64'(occupancy), 64'd1);
      check("s1_idle_valid", 64'(mem_if.mem_req_valid), 64'd0);
      step(acc);
      check("s1_k_valid", 64'(mem_if.mem_req_valid), 64'd1);
      check("s1_k_tag", 64'(mem_if.mem_req_tag), 64'h0A);
      check("s1_k_addr", 64'(mem_if.mem_req_addr), 64'h100);
      step(acc);
      check("s1_l_tag", 64'(mem_if.mem_req_tag), 64'h0B);
      check("s1_l_addr", 64'(mem_if.mem_req_addr), 64'h200);
      step(acc);
      check("s1_end_valid", 64'(mem_if.mem_req_valid), 64'd0);
      check("s1_end_occ", 64'(occupancy), 64'd0);

      // Fill with ready low until the stall engages
      mem_if.mem_req_ready = 1'b0;
      j = 1;
      set_req(j, 42'h1000 + 42'(j), 42'h2000 + 42'(j));
      request_valid = 1'b1;
      max_occ = 0;
      for (int c = 0; c < 24; c++) begin
         step(acc);
         if (acc && j < 15) begin
            j++;
            set_req(j, 42'h1000 + 42'(j), 42'h2000 + 42'(j));
         end
         if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
         check("s2_stall_vs_occ", 64'(stall), 64'(occupancy >= 5'd14));
      end
      check("s2_accepted", 64'(j - 1), 64'd14);
      check("s2_occ", 64'(occupancy), 64'd14);
      check("s2_stall", 64'(stall), 64'd1);
      check("s2_max_occ", 64'(max_occ), 64'd14);
      check("s2_ovf", 64'(overflow_err), 64'd0);
      check("s2_head_tag", 64'(mem_if.mem_req_tag), 64'h02);

      // Drain; the held 15th request must be accepted exactly once
      mem_if.mem_req_ready = 1'b1;
      held_acc = 0;
      saw_fall = 1'b0;
      reads0 = n_reads;
      for (int c = 0; c < 40; c++) begin
         step(acc);
         if (acc) begin
            held_acc++;
            request_valid = 1'b0;
         end
         if (!stall && occupancy == 5'd13) saw_fall = 1'b1;
         if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      end
      check("s3_reads", 64'(n_reads - reads0), 64'd30);
      check("s3_held_acc", 64'(held_acc), 64'd1);
      check("s3_stall_fell", 64'(saw_fall), 64'd1);
      check("s3_max_occ", 64'(max_occ), 64'd14);
      check("s3_model_empty", 64'(exp_q.size()), 64'd0);
      check("s3_occ", 64'(occupancy), 64'd0);
      check("s3_idle", 64'(mem_if.mem_req_valid), 64'd0);

      // Steady push-with-pop: occupancy pinned at 3 while pointers wrap
      mem_if.mem_req_ready = 1'b0;
      for (rn = 20; rn < 23; rn++) begin
         set_req(rn, 42'h3000 + 42'(rn), 42'h4000 + 42'(rn));
         request_valid = 1'b1;
         step(acc);
      end
      request_valid = 1'b0;
      check("s4_preload_occ", 64'(occupancy), 64'd3);
      mem_if.mem_req_ready = 1'b1;
      reads0 = n_reads;
      for (int c = 0; c < 40; c++) begin
         request_valid = mem_if.mem_req_valid && mem_if.mem_req_tag[0];
         set_req(rn, 42'h3000 + 42'(rn), 42'h4000 + 42'(rn));
         step(acc);
         if (acc) rn++;
         check("s4_occ_const", 64'(occupancy), 64'd3);
      end
      request_valid = 1'b0;
      check("s4_pushed", 64'(rn - 23), 64'd20);
      repeat (8) step(acc);
      check("s4_reads", 64'(n_reads - reads0), 64'd46);
      check("s4_model_empty", 64'(exp_q.size()), 64'd0);
      check("s4_occ_end", 64'(occupancy), 64'd0);

      // SEND_L held by ready low while request inputs change
      mem_if.mem_req_ready = 1'b0;
      set_req(30, 42'h5555, 42'h6666);
      request_valid = 1'b1;
      step(acc);
      request_valid = 1'b0;
      step(acc);
      mem_if.mem_req_ready = 1'b1;
      step(acc);
      mem_if.mem_req_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("s5_valid", 64'(mem_if.mem_req_valid), 64'd1);
         check("s5_tag", 64'(mem_if.mem_req_tag), 64'h3D);
         check("s5_addr", 64'(mem_if.mem_req_addr), 64'h6666);
         addr_k = {10'h0, $urandom()};
         addr_l = {10'h0, $urandom()};
         step(acc);
      end

      // Asynchronous reset in the middle of SEND_L
      #2;
      rst = 1'b0;
      #1;
      check("s6_valid", 64'(mem_if.mem_req_valid), 64'd0);
      check("s6_addr", 64'(mem_if.mem_req_addr), 64'd0);
      check("s6_tag", 64'(mem_if.mem_req_tag), 64'd0);
      check("s6_occ", 64'(occupancy), 64'd0);
      check("s6_stall", 64'(stall), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      rd_phase = 1'b0;
      mem_if.mem_req_ready = 1'b1;
      set_req(9, 42'h777, 42'h888);
      request_valid = 1'b1;
      step(acc);
      request_valid = 1'b0;
      check("s6_occ_push", 64'(occupancy), 64'd1);
      step(acc);
      check("s6_k_tag", 64'(mem_if.mem_req_tag), 64'h12);
      check("s6_k_addr", 64'(mem_if.mem_req_addr), 64'h777);
      step(acc);
      check("s6_l_tag", 64'(mem_if.mem_req_tag), 64'h13);
      step(acc);
      check("s6_occ_end", 64'(occupancy), 64'd0);
      check("final_ovf", 64'(overflow_err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
